// File: rtl/modular_inverse.sv
// Modular inverse b = a^-1 mod base via iterative extended Euclid, one quotient step per clock.
// Latency 3 + Euclid steps from start to valid_out; starts are ignored while busy.
module modular_inverse #(
  parameter int WIDTH = 512
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] base,
  input  logic             valid_in,
  output logic [WIDTH-1:0] b_out,
  output logic             valid_out,
  output logic             busy_out,
  output logic             error_out
);

  typedef enum logic [2:0] {
    IDLE,
    REDUCE,
    ITER,
    FIX,
    DONE
  } state_t;

  state_t                  state_q;
  logic [WIDTH-1:0]        a_q;
  logic [WIDTH-1:0]        base_q;
  logic [WIDTH-1:0]        r0_q;
  logic [WIDTH-1:0]        r1_q;
  logic signed [WIDTH:0]   t0_q;
  logic signed [WIDTH:0]   t1_q;
  logic [WIDTH-1:0]        b_q;
  logic                    valid_q;
  logic                    busy_q;
  logic                    error_q;

  logic [WIDTH-1:0]        quot;
  logic [WIDTH-1:0]        r1_d;
  logic signed [WIDTH:0]   t1_d;
  logic [WIDTH-1:0]        a_red;
  logic [WIDTH-1:0]        b_fix;

  // Products are truncated to operand width; Euclid bounds keep them exact.
  always_comb begin
    quot  = (r1_q != '0) ? (r0_q / r1_q) : '0;
    r1_d  = r0_q - quot * r1_q;
    t1_d  = t0_q - $signed({1'b0, quot}) * t1_q;
    a_red = (base_q != '0) ? (a_q % base_q) : '0;
    b_fix = t0_q[WIDTH] ? (t0_q[WIDTH-1:0] + base_q) : t0_q[WIDTH-1:0];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      a_q     <= '0;
      base_q  <= '0;
      r0_q    <= '0;
      r1_q    <= '0;
      t0_q    <= '0;
      t1_q    <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (valid_in) begin
            a_q     <= a_in;
            base_q  <= base;
            busy_q  <= 1'b1;
            state_q <= REDUCE;
          end
        end
        REDUCE: begin
          r0_q <= base_q;
          r1_q <= a_red;
          t0_q <= '0;
          t1_q <= {{WIDTH{1'b0}}, 1'b1};
          if ((base_q < WIDTH'(2)) || (a_red == '0)) begin
            b_q     <= '0;
            error_q <= 1'b1;
            valid_q <= 1'b1;
            state_q <= DONE;
          end else begin
            state_q <= ITER;
          end
        end
        ITER: begin
          r0_q <= r1_q;
          r1_q <= r1_d;
          t0_q <= t1_q;
          t1_q <= t1_d;
          if (r1_d == '0) state_q <= FIX;
        end
        FIX: begin
          // r0 now holds gcd(a, base); only gcd 1 has an inverse.
          if (r0_q != WIDTH'(1)) begin
            b_q     <= '0;
            error_q <= 1'b1;
          end else begin
            b_q     <= b_fix;
            error_q <= 1'b0;
          end
          valid_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign b_out     = b_q;
  assign valid_out = valid_q;
  assign busy_out  = busy_q;
  assign error_out = error_q;

endmodule

// File: tb/tb_modular_inverse.sv
// Bench for modular_inverse: 16-bit vector table, random 16-bit and 512-bit operands, busy/reset corners.
module tb_modular_inverse;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] a16, base16, bo16;
  logic        v16, vo16, busy16, err16;
  logic [511:0] a5, base5, bo5;
  logic        v5, vo5, busy5, err5;

  int checks = 0;
  int errors = 0;

  modular_inverse #(.WIDTH(16)) dut16 (
    .clk_in(clk), .rst_in(rst), .a_in(a16), .base(base16), .valid_in(v16),
    .b_out(bo16), .valid_out(vo16), .busy_out(busy16), .error_out(err16)
  );

  modular_inverse #(.WIDTH(512)) dut512 (
    .clk_in(clk), .rst_in(rst), .a_in(a5), .base(base5), .valid_in(v5),
    .b_out(bo5), .valid_out(vo5), .busy_out(busy5), .error_out(err5)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] base;
    logic [15:0] b;
    logic        err;
  } vec_t;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int unsigned gcd_u(input int unsigned x, input int unsigned y);
    int unsigned t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic int steps_u(input int unsigned x, input int unsigned y);
    int n = 0;
    int unsigned t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
      n++;
    end
    return n;
  endfunction

  function automatic logic [511:0] gcd_w(input logic [511:0] x, input logic [511:0] y);
    logic [511:0] t;
    while (y != '0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic int steps_w(input logic [511:0] x, input logic [511:0] y);
    int n = 0;
    logic [511:0] t;
    while (y != '0) begin
      t = x % y;
      x = y;
      y = t;
      n++;
    end
    return n;
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference: brute-force search for x with (a*x) mod base == 1; steps = -1 when rejected up front.
  task automatic model16(input int unsigned a, input int unsigned base,
                         output logic [15:0] b, output logic err, output int steps);
    int unsigned ar;
    b = '0;
    err = 1'b1;
    steps = -1;
    if (base < 2) return;
    ar = a % base;
    if (ar == 0) return;
    steps = steps_u(base, ar);
    if (gcd_u(base, ar) != 1) return;
    for (int unsigned x = 1; x < base; x++) begin
      if ((ar * x) % base == 1) begin
        b = 16'(x);
        err = 1'b0;
        break;
      end
    end
  endtask

  task automatic run16(input string name, input logic [15:0] a, input logic [15:0] base, input bit poke,
                       input logic [15:0] exp_b, input logic exp_err, input int exp_steps);
    int cyc = 0;
    int extra = 0;
    bit busy_ok = 1'b1;
    @(negedge clk);
    a16 = a;
    base16 = base;
    v16 = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        v16 = 1'b0;
        a16 = 16'($urandom);
        base16 = 16'($urandom);
      end
      if (poke && cyc == 4) v16 = 1'b1;
      if (poke && cyc == 5) v16 = 1'b0;
      if (!busy16) busy_ok = 1'b0;
    end while (!vo16 && cyc < 1000);
    check($sformatf("%s done", name), 512'(vo16), 512'd1);
    check($sformatf("%s b_out", name), 512'(bo16), 512'(exp_b));
    check($sformatf("%s error_out", name), 512'(err16), 512'(exp_err));
    check($sformatf("%s busy", name), 512'(busy_ok), 512'd1);
    if (exp_steps >= 0) check($sformatf("%s latency", name), 512'(cyc), 512'(3 + exp_steps));
    repeat (4) begin
      @(negedge clk);
      if (vo16) extra++;
    end
    check($sformatf("%s single pulse", name), 512'(extra), 512'd0);
    check($sformatf("%s hold", name), 512'(bo16), 512'(exp_b));
    check($sformatf("%s idle", name), 512'(busy16), 512'd0);
  endtask

  task automatic run512(input logic [511:0] a, input logic [511:0] base,
                        output logic [511:0] b, output logic err, output int cyc, output bit seen);
    cyc = 0;
    @(negedge clk);
    a5 = a;
    base5 = base;
    v5 = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        v5 = 1'b0;
        a5 = rnd512();
        base5 = rnd512();
      end
    end while (!vo5 && cyc < 3000);
    seen = vo5;
    b = bo5;
    err = err5;
  endtask

  initial begin
    vec_t tbl[12];
    logic [15:0] mb;
    logic me;
    int ms;
    logic [511:0] wa, wbase, wb;
    logic [1023:0] prod;
    logic we;
    int wcyc;
    bit wseen;
    bit saw;

    tbl[0]  = '{a: 16'd3,     base: 16'd11,    b: 16'd4,     err: 1'b0};
    tbl[1]  = '{a: 16'd10,    base: 16'd17,    b: 16'd12,    err: 1'b0};
    tbl[2]  = '{a: 16'd20,    base: 16'd7,     b: 16'd6,     err: 1'b0};
    tbl[3]  = '{a: 16'd6,     base: 16'd9,     b: 16'd0,     err: 1'b1};
    tbl[4]  = '{a: 16'd0,     base: 16'd13,    b: 16'd0,     err: 1'b1};
    tbl[5]  = '{a: 16'd5,     base: 16'd1,     b: 16'd0,     err: 1'b1};
    tbl[6]  = '{a: 16'd5,     base: 16'd0,     b: 16'd0,     err: 1'b1};
    tbl[7]  = '{a: 16'd26,    base: 16'd13,    b: 16'd0,     err: 1'b1};
    tbl[8]  = '{a: 16'd1,     base: 16'd2,     b: 16'd1,     err: 1'b0};
    tbl[9]  = '{a: 16'd65535, base: 16'd65534, b: 16'd1,     err: 1'b0};
    tbl[10] = '{a: 16'd21,    base: 16'd34,    b: 16'd13,    err: 1'b0};
    tbl[11] = '{a: 16'd2,     base: 16'd65535, b: 16'd32768, err: 1'b0};

    rst = 1'b1;
    v16 = 1'b0; a16 = '0; base16 = '0;
    v5 = 1'b0;  a5 = '0;  base5 = '0;
    repeat (3) @(negedge clk);
    check("reset b16", 512'(bo16), 512'd0);
    check("reset valid16", 512'(vo16), 512'd0);
    check("reset busy16", 512'(busy16), 512'd0);
    check("reset err16", 512'(err16), 512'd0);
    check("reset b512", bo5, 512'd0);
    check("reset valid512", 512'(vo5), 512'd0);
    check("reset busy512", 512'(busy5), 512'd0);
    check("reset err512", 512'(err5), 512'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      model16(tbl[i].a, tbl[i].base, mb, me, ms);
      run16($sformatf("vec%0d", i), tbl[i].a, tbl[i].base, 1'b0, tbl[i].b, tbl[i].err, ms);
    end

    for (int i = 0; i < 30; i++) begin
      logic [15:0] ra, rb;
      rb = 16'($urandom_range(2, 65535));
      ra = 16'($urandom_range(0, 65535));
      model16(ra, rb, mb, me, ms);
      run16($sformatf("rand16_%0d a=%0d base=%0d", i, ra, rb), ra, rb, 1'b0, mb, me, ms);
    end

    // Start pulse while busy must be ignored.
    model16(17711, 28657, mb, me, ms);
    run16("busy poke", 16'd17711, 16'd28657, 1'b1, mb, me, ms);

    // Reset in the middle of the iteration.
    @(negedge clk);
    a16 = 16'd17711;
    base16 = 16'd28657;
    v16 = 1'b1;
    @(negedge clk);
    v16 = 1'b0;
    repeat (4) @(negedge clk);
    check("busy before reset", 512'(busy16), 512'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset b", 512'(bo16), 512'd0);
    check("midreset valid", 512'(vo16), 512'd0);
    check("midreset busy", 512'(busy16), 512'd0);
    check("midreset err", 512'(err16), 512'd0);
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (vo16) saw = 1'b1;
    end
    check("midreset no valid", 512'(saw), 512'd0);
    model16(3, 11, mb, me, ms);
    run16("after reset", 16'd3, 16'd11, 1'b0, mb, me, ms);

    for (int i = 0; i < 3; i++) begin
      do begin
        wa = rnd512();
        wbase = rnd512();
        wa[511] = 1'b1;
        wbase[511] = 1'b0;
        wbase[510] = 1'b1;
      end while (gcd_w(wbase, wa % wbase) != 512'd1);
      ms = steps_w(wbase, wa % wbase);
      run512(wa, wbase, wb, we, wcyc, wseen);
      prod = ({512'b0, wa} * {512'b0, wb}) % {512'b0, wbase};
      check($sformatf("w512_%0d done", i), 512'(wseen), 512'd1);
      check($sformatf("w512_%0d error_out", i), 512'(we), 512'd0);
      check($sformatf("w512_%0d range", i), 512'(wb < wbase), 512'd1);
      check($sformatf("w512_%0d a*b mod base", i), 512'(prod == 1024'd1), 512'd1);
      check($sformatf("w512_%0d latency", i), 512'(wcyc), 512'(3 + ms));
    end

    wbase = rnd512() >> 2;
    wbase[0] = 1'b1;
    wa = wbase * 512'd3;
    run512(wa, wbase, wb, we, wcyc, wseen);
    check("w512 multiple done", 512'(wseen), 512'd1);
    check("w512 multiple error_out", 512'(we), 512'd1);
    check("w512 multiple b_out", wb, 512'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
